door_direction_sensor: RTL and testbench

//  Front end of the student counter. Watches two door light-beams (outer, inner) and emits one-cycle
//  inc_pulse / dec_pulse events that the counter consumes in place of push buttons. Both beams are

---
 rtl/door_direction_sensor.sv | 201 ++++++++++++++++++++
 tb/tb_door_direction_sensor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/door_direction_sensor.sv
`default_nettype none
// ============================================================================
// Module   : door_direction_sensor
// Brief    : Two-beam door sensor: synchronise, debounce and decode direction
//            into one-cycle entry/exit/error pulses.
// Revision : 1.0
// ============================================================================
module door_direction_sensor #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 100000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       beam_outer,
    input  logic       beam_inner,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       seq_error,
    output logic       beam_outer_db,
    output logic       beam_inner_db,
    output logic [2:0] state_out
);

    localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_E1       = 3'd1,
        S_E2       = 3'd2,
        S_E3       = 3'd3,
        S_X1       = 3'd4,
        S_X2       = 3'd5,
        S_X3       = 3'd6,
        S_WAIT_CLR = 3'd7
    } state_t;

    localparam logic [1:0] c_EV_NONE = 2'd0;
    localparam logic [1:0] c_EV_INC  = 2'd1;
    localparam logic [1:0] c_EV_DEC  = 2'd2;
    localparam logic [1:0] c_EV_ERR  = 2'd3;

    logic [1:0] w_raw;
    logic [1:0] w_db;

    assign w_raw = {beam_outer, beam_inner};

    // Bit 1 is the outer beam, bit 0 the inner beam.
    generate
        for (genvar g = 0; g < 2; g++) begin : g_debounce
            logic              r_s1;
            logic              r_s2;
            logic              r_db;
            logic [c_DB_W-1:0] r_cnt;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_s1  <= 1'b0;
                    r_s2  <= 1'b0;
                    r_db  <= 1'b0;
                    r_cnt <= '0;
                end else begin
                    r_s1 <= w_raw[g];
                    r_s2 <= r_s1;
                    if (r_s2 != r_db) begin
                        if (r_cnt == c_DB_LAST) begin
                            r_db  <= r_s2;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end

            assign w_db[g] = r_db;
        end
    endgenerate

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        w_ev;
    logic [c_TO_W-1:0] r_dwell;
    logic              r_inc;
    logic              r_dec;
    logic              r_err;
    logic              w_active;

    assign w_active = (r_state != S_IDLE) && (r_state != S_WAIT_CLR);

    always_comb begin
        w_next = r_state;
        w_ev   = c_EV_NONE;
        case (r_state)
            S_IDLE: begin
                case (w_db)
                    2'b10:   w_next = S_E1;
                    2'b01:   w_next = S_X1;
                    2'b11:   begin w_next = S_WAIT_CLR; w_ev = c_EV_ERR; end
                    default: ;
                endcase
            end
            S_E1: begin
                case (w_db)
                    2'b11:   w_next = S_E2;
                    2'b00:   w_next = S_IDLE;
                    2'b01:   begin w_next = S_WAIT_CLR; w_ev = c_EV_ERR; end
                    default: ;
                endcase
            end
            S_E2: begin
                case (w_db)
                    2'b01:   w_next = S_E3;
                    2'b10:   w_next = S_E1;
                    2'b00:   begin w_next = S_WAIT_CLR; w_ev = c_EV_ERR; end
                    default: ;
                endcase
            end
            S_E3: begin
                case (w_db)
                    2'b00:   begin w_next = S_IDLE; w_ev = c_EV_INC; end
                    2'b11:   w_next = S_E2;
                    2'b10:   begin w_next = S_WAIT_CLR; w_ev = c_EV_ERR; end
                    default: ;
                endcase
            end
            S_X1: begin
                case (w_db)
                    2'b11:   w_next = S_X2;
                    2'b00:   w_next = S_IDLE;
                    2'b10:   begin w_next = S_WAIT_CLR; w_ev = c_EV_ERR; end
                    default: ;
                endcase
            end
            S_X2: begin
                case (w_db)
                    2'b10:   w_next = S_X3;
                    2'b01:   w_next = S_X1;
                    2'b00:   begin w_next = S_WAIT_CLR; w_ev = c_EV_ERR; end
                    default: ;
                endcase
            end
            S_X3: begin
                case (w_db)
                    2'b00:   begin w_next = S_IDLE; w_ev = c_EV_DEC; end
                    2'b11:   w_next = S_X2;
                    2'b01:   begin w_next = S_WAIT_CLR; w_ev = c_EV_ERR; end
                    default: ;
                endcase
            end
            default: begin
                if (w_db == 2'b00) w_next = S_IDLE;
            end
        endcase
        // A dwell that reaches the limit without a table move discards the sequence.
        if (w_active && (w_next == r_state) && (r_dwell == c_TO_LAST)) begin
            w_next = S_WAIT_CLR;
            w_ev   = c_EV_ERR;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_WAIT_CLR;
            r_dwell <= '0;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
            r_err   <= 1'b0;
        end else if (!enable) begin
            r_state <= S_WAIT_CLR;
            r_dwell <= '0;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_inc   <= (w_ev == c_EV_INC);
            r_dec   <= (w_ev == c_EV_DEC);
            r_err   <= (w_ev == c_EV_ERR);
            if (w_next != r_state) begin
                r_dwell <= '0;
            end else if (r_dwell != c_TO_LAST) begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

    assign inc_pulse     = r_inc;
    assign dec_pulse     = r_dec;
    assign seq_error     = r_err;
    assign beam_outer_db = w_db[1];
    assign beam_inner_db = w_db[0];
    assign state_out     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_door_direction_sensor.sv
`default_nettype none
// ============================================================================
// Module   : tb_door_direction_sensor
// Brief    : Directed scoreboard bench for door_direction_sensor.
// Revision : 1.0
// ============================================================================
module tb_door_direction_sensor;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       beam_outer;
    logic       beam_inner;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       seq_error;
    logic       beam_outer_db;
    logic       beam_inner_db;
    logic [2:0] state_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected events: {state[2:0], inc, dec, err}, one per state_out change.
    logic [5:0] exp_q[$];
    logic       mon_on = 1'b0;
    logic [2:0] prev_state = 3'd7;

    door_direction_sensor #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clock        (clk),
        .reset        (rst),
        .enable       (enable),
        .beam_outer   (beam_outer),
        .beam_inner   (beam_inner),
        .inc_pulse    (inc_pulse),
        .dec_pulse    (dec_pulse),
        .seq_error    (seq_error),
        .beam_outer_db(beam_outer_db),
        .beam_inner_db(beam_inner_db),
        .state_out    (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beams(input logic o, input logic i);
        beam_outer = o;
        beam_inner = i;
    endtask

    task automatic push(input logic [2:0] st, input logic inc, input logic dec, input logic err);
        exp_q.push_back({st, inc, dec, err});
    endtask

    // Monitor: every state change or pulse must match the next queued event.
    always @(negedge clk) begin
        if (mon_on) begin
            if ((state_out !== prev_state) || inc_pulse || dec_pulse || seq_error) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got state %0d inc %b dec %b err %b, none expected at %0t",
                             state_out, inc_pulse, dec_pulse, seq_error, $time);
                end else begin
                    chk("event", {2'b00, state_out, inc_pulse, dec_pulse, seq_error},
                        {2'b00, exp_q.pop_front()});
                end
            end
            prev_state <= state_out;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, got %0t required below 100000", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        int   found;
        rst    = 1'b1;
        enable = 1'b1;
        beams(1'b0, 1'b0);
        step(3);
        chk("reset_state", {5'd0, state_out}, 8'd7);
        chk("reset_pulses", {5'd0, inc_pulse, dec_pulse, seq_error}, 8'd0);
        chk("reset_db", {6'd0, beam_outer_db, beam_inner_db}, 8'd0);

        // Leaving reset with beams clear: WAIT_CLR -> IDLE.
        push(3'd0, 0, 0, 0);
        mon_on = 1'b1;
        rst    = 1'b0;
        step(10);

        // Entry 00,10,11,01,00.
        push(3'd1, 0, 0, 0); beams(1, 0); step(10);
        push(3'd2, 0, 0, 0); beams(1, 1); step(10);
        push(3'd3, 0, 0, 0); beams(0, 1); step(10);
        push(3'd0, 1, 0, 0); beams(0, 0); step(10);

        // Exit 00,01,11,10,00.
        push(3'd4, 0, 0, 0); beams(0, 1); step(10);
        push(3'd5, 0, 0, 0); beams(1, 1); step(10);
        push(3'd6, 0, 0, 0); beams(1, 0); step(10);
        push(3'd0, 0, 1, 0); beams(0, 0); step(10);

        // Glitches of 3 and 2 cycles must not reach the debounced output.
        seen = 1'b0;
        beams(1, 0); step(3); beams(0, 0);
        for (int k = 0; k < 10; k++) begin step(1); seen |= beam_outer_db; end
        beams(1, 0); step(2); beams(0, 0);
        for (int k = 0; k < 10; k++) begin step(1); seen |= beam_outer_db; end
        chk("glitch_db", {7'd0, seen}, 8'd0);
        chk("glitch_state", {5'd0, state_out}, 8'd0);

        // Stable level: debounced value appears 2+4 edges after the raw change.
        push(3'd1, 0, 0, 0);
        beams(1, 0);
        step(5);
        chk("db_latency_5", {7'd0, beam_outer_db}, 8'd0);
        step(1);
        chk("db_latency_6", {7'd0, beam_outer_db}, 8'd1);
        step(10);

        // Back-out 10,11,10,00: no pulses.
        push(3'd2, 0, 0, 0); beams(1, 1); step(10);
        push(3'd1, 0, 0, 0); beams(1, 0); step(10);
        push(3'd0, 0, 0, 0); beams(0, 0); step(10);

        // Timeout in E1.
        push(3'd1, 0, 0, 0);
        push(3'd7, 0, 0, 1);
        beams(1, 0);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            step(1);
            if (state_out == 3'd1) found = 1;
        end
        chk("enter_e1", found[7:0], 8'd1);
        step(49);
        chk("timeout_49", {4'd0, state_out, seq_error}, {4'd0, 3'd1, 1'b0});
        step(1);
        chk("timeout_50", {4'd0, state_out, seq_error}, {4'd0, 3'd7, 1'b1});
        step(10);
        push(3'd0, 0, 0, 0); beams(0, 0); step(10);

        // Both beams at once from IDLE is illegal.
        push(3'd7, 0, 0, 1); beams(1, 1); step(10);
        push(3'd0, 0, 0, 0); beams(0, 0); step(10);

        // Reset while in E3.
        push(3'd1, 0, 0, 0); beams(1, 0); step(10);
        push(3'd2, 0, 0, 0); beams(1, 1); step(10);
        push(3'd3, 0, 0, 0); beams(0, 1); step(10);
        push(3'd7, 0, 0, 0);
        rst = 1'b1;
        step(1);
        chk("midreset_state", {5'd0, state_out}, 8'd7);
        chk("midreset_outs", {3'd0, inc_pulse, dec_pulse, seq_error, beam_outer_db, beam_inner_db}, 8'd0);
        beams(0, 0);
        step(2);
        push(3'd0, 0, 0, 0);
        rst = 1'b0;
        step(10);

        // Enable dropped in E2.
        push(3'd1, 0, 0, 0); beams(1, 0); step(10);
        push(3'd2, 0, 0, 0); beams(1, 1); step(10);
        push(3'd7, 0, 0, 0);
        enable = 1'b0;
        step(10);
        beams(0, 0);
        step(10);
        chk("disabled_state", {5'd0, state_out}, 8'd7);
        push(3'd0, 0, 0, 0);
        enable = 1'b1;
        step(10);

        chk("queue_drained", exp_q.size() > 255 ? 8'hFF : exp_q.size()[7:0], 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
